// File: rtl/l1_cache_msi_ctrl.sv
// Direct-mapped L1 data cache with an MSI coherence controller toward the directory.
// One outstanding CPU request; directory snoops are serviced in every controller state.
module l1_cache_msi_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int INDEX_W = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              msg_valid,
    output logic [2:0]        msg_type,
    output logic [ADDR_W-1:0] msg_addr,
    input  logic              fill_valid,
    input  logic [ADDR_W-1:0] fill_addr,
    input  logic [DATA_W-1:0] fill_data,
    input  logic              snp_valid,
    input  logic [2:0]        snp_type,
    input  logic [ADDR_W-1:0] snp_addr,
    output logic              wb_valid,
    output logic [ADDR_W-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data
);
    localparam int LINES = 2 ** INDEX_W;
    localparam int TAG_W = ADDR_W - INDEX_W;

    localparam logic [1:0] LS_I = 2'b00;
    localparam logic [1:0] LS_S = 2'b10;
    localparam logic [1:0] LS_M = 2'b11;

    localparam logic [2:0] MT_RD  = 3'b100;
    localparam logic [2:0] MT_WR  = 3'b010;
    localparam logic [2:0] MT_INV = 3'b001;

    // WB_HOLD: victim write-back waiting because a snoop write-back owns the wb port
    typedef enum logic [2:0] {IDLE, WB_HOLD, WB, REQ, WAIT, RESP} state_t;

    state_t              state_q, state_d;
    logic [1:0]          lstate_q [LINES];
    logic [1:0]          lstate_d [LINES];
    logic [TAG_W-1:0]    tag_q    [LINES];
    logic [TAG_W-1:0]    tag_d    [LINES];
    logic [DATA_W-1:0]   data_q   [LINES];
    logic [DATA_W-1:0]   data_d   [LINES];

    logic                req_we_q, req_we_d;
    logic [ADDR_W-1:0]   req_addr_q, req_addr_d;
    logic [DATA_W-1:0]   req_wdata_q, req_wdata_d;
    logic [ADDR_W-1:0]   vic_addr_q, vic_addr_d;
    logic [DATA_W-1:0]   vic_data_q, vic_data_d;
    logic                upgrade_q, upgrade_d;

    logic                cpu_ack_q, cpu_ack_d;
    logic [DATA_W-1:0]   cpu_rdata_q, cpu_rdata_d;
    logic                msg_valid_q, msg_valid_d;
    logic [2:0]          msg_type_q, msg_type_d;
    logic [ADDR_W-1:0]   msg_addr_q, msg_addr_d;
    logic                wb_valid_q, wb_valid_d;
    logic [ADDR_W-1:0]   wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]   wb_data_q, wb_data_d;

    logic [INDEX_W-1:0]  cpu_idx, snp_idx, req_idx;
    logic [TAG_W-1:0]    cpu_tag, snp_tag, req_tag;
    logic                snp_hit, snp_wb, accept, cpu_hit;

    assign cpu_idx = cpu_addr[INDEX_W-1:0];
    assign cpu_tag = cpu_addr[ADDR_W-1:INDEX_W];
    assign snp_idx = snp_addr[INDEX_W-1:0];
    assign snp_tag = snp_addr[ADDR_W-1:INDEX_W];
    assign req_idx = req_addr_q[INDEX_W-1:0];
    assign req_tag = req_addr_q[ADDR_W-1:INDEX_W];

    assign snp_hit = snp_valid && (lstate_q[snp_idx] != LS_I) && (tag_q[snp_idx] == snp_tag);
    assign snp_wb  = snp_hit && (lstate_q[snp_idx] == LS_M) && (snp_type[2] || snp_type[1]);

    // A snoop to the same index takes the array this cycle; the CPU retries next cycle.
    assign cpu_ready = !reset && (state_q == IDLE) && !(snp_valid && (snp_idx == cpu_idx));
    assign accept    = cpu_req && cpu_ready;
    assign cpu_hit   = (lstate_q[cpu_idx] != LS_I) && (tag_q[cpu_idx] == cpu_tag);

    always_comb begin
        state_d     = state_q;
        lstate_d    = lstate_q;
        tag_d       = tag_q;
        data_d      = data_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_wdata_d = req_wdata_q;
        vic_addr_d  = vic_addr_q;
        vic_data_d  = vic_data_q;
        upgrade_d   = upgrade_q;
        cpu_ack_d   = 1'b0;
        cpu_rdata_d = '0;
        msg_valid_d = 1'b0;
        msg_type_d  = '0;
        msg_addr_d  = '0;
        wb_valid_d  = 1'b0;
        wb_addr_d   = '0;
        wb_data_d   = '0;

        if (snp_hit) begin
            if (snp_type[0] || snp_type[1]) lstate_d[snp_idx] = LS_I;
            else if (snp_type[2])           lstate_d[snp_idx] = LS_S;
        end
        if (snp_wb) begin
            wb_valid_d = 1'b1;
            wb_addr_d  = snp_addr;
            wb_data_d  = data_q[snp_idx];
        end

        case (state_q)
            IDLE: begin
                if (accept) begin
                    req_we_d    = cpu_we;
                    req_addr_d  = cpu_addr;
                    req_wdata_d = cpu_wdata;
                    vic_addr_d  = {tag_q[cpu_idx], cpu_idx};
                    vic_data_d  = data_q[cpu_idx];
                    upgrade_d   = 1'b0;
                    if (cpu_hit && (!cpu_we || lstate_q[cpu_idx] == LS_M)) begin
                        if (cpu_we) data_d[cpu_idx] = cpu_wdata;
                        cpu_ack_d   = 1'b1;
                        cpu_rdata_d = cpu_we ? cpu_wdata : data_q[cpu_idx];
                        state_d     = RESP;
                    end else if (cpu_hit) begin
                        data_d[cpu_idx]   = cpu_wdata;
                        lstate_d[cpu_idx] = LS_M;
                        upgrade_d         = 1'b1;
                        msg_valid_d       = 1'b1;
                        msg_type_d        = MT_INV;
                        msg_addr_d        = cpu_addr;
                        state_d           = REQ;
                    end else if (lstate_q[cpu_idx] == LS_M) begin
                        if (snp_wb) begin
                            state_d = WB_HOLD;
                        end else begin
                            wb_valid_d = 1'b1;
                            wb_addr_d  = {tag_q[cpu_idx], cpu_idx};
                            wb_data_d  = data_q[cpu_idx];
                            state_d    = WB;
                        end
                    end else begin
                        msg_valid_d = 1'b1;
                        msg_type_d  = cpu_we ? MT_WR : MT_RD;
                        msg_addr_d  = cpu_addr;
                        state_d     = REQ;
                    end
                end
            end
            WB_HOLD: begin
                if (!snp_wb) begin
                    wb_valid_d = 1'b1;
                    wb_addr_d  = vic_addr_q;
                    wb_data_d  = vic_data_q;
                    state_d    = WB;
                end
            end
            WB: begin
                msg_valid_d = 1'b1;
                msg_type_d  = req_we_q ? MT_WR : MT_RD;
                msg_addr_d  = req_addr_q;
                state_d     = REQ;
            end
            REQ: begin
                if (upgrade_q) begin
                    cpu_ack_d   = 1'b1;
                    cpu_rdata_d = req_wdata_q;
                    state_d     = RESP;
                end else begin
                    state_d = WAIT;
                end
            end
            WAIT: begin
                // Fill is applied after any same-cycle snoop so the new line wins.
                if (fill_valid && (fill_addr == req_addr_q)) begin
                    tag_d[req_idx]    = req_tag;
                    data_d[req_idx]   = req_we_q ? req_wdata_q : fill_data;
                    lstate_d[req_idx] = req_we_q ? LS_M : LS_S;
                    cpu_ack_d         = 1'b1;
                    cpu_rdata_d       = req_we_q ? req_wdata_q : fill_data;
                    state_d           = RESP;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            for (int i = 0; i < LINES; i++) begin
                lstate_q[i] <= LS_I;
                tag_q[i]    <= '0;
                data_q[i]   <= '0;
            end
            req_we_q    <= 1'b0;
            req_addr_q  <= '0;
            req_wdata_q <= '0;
            vic_addr_q  <= '0;
            vic_data_q  <= '0;
            upgrade_q   <= 1'b0;
            cpu_ack_q   <= 1'b0;
            cpu_rdata_q <= '0;
            msg_valid_q <= 1'b0;
            msg_type_q  <= '0;
            msg_addr_q  <= '0;
            wb_valid_q  <= 1'b0;
            wb_addr_q   <= '0;
            wb_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            lstate_q    <= lstate_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_wdata_q <= req_wdata_d;
            vic_addr_q  <= vic_addr_d;
            vic_data_q  <= vic_data_d;
            upgrade_q   <= upgrade_d;
            cpu_ack_q   <= cpu_ack_d;
            cpu_rdata_q <= cpu_rdata_d;
            msg_valid_q <= msg_valid_d;
            msg_type_q  <= msg_type_d;
            msg_addr_q  <= msg_addr_d;
            wb_valid_q  <= wb_valid_d;
            wb_addr_q   <= wb_addr_d;
            wb_data_q   <= wb_data_d;
        end
    end

    assign cpu_ack   = cpu_ack_q;
    assign cpu_rdata = cpu_rdata_q;
    assign msg_valid = msg_valid_q;
    assign msg_type  = msg_type_q;
    assign msg_addr  = msg_addr_q;
    assign wb_valid  = wb_valid_q;
    assign wb_addr   = wb_addr_q;
    assign wb_data   = wb_data_q;

endmodule

// File: tb/tb_l1_cache_msi_ctrl.sv
// Bench for l1_cache_msi_ctrl: directed scenarios plus random CPU/snoop traffic
// checked against a transaction-level MSI model of the two cache lines.
module tb_l1_cache_msi_ctrl;
    logic       clk = 1'b0;
    logic       reset;
    logic       cpu_req, cpu_we;
    logic [7:0] cpu_addr, cpu_wdata;
    logic       cpu_ready, cpu_ack;
    logic [7:0] cpu_rdata;
    logic       msg_valid;
    logic [2:0] msg_type;
    logic [7:0] msg_addr;
    logic       fill_valid;
    logic [7:0] fill_addr, fill_data;
    logic       snp_valid;
    logic [2:0] snp_type;
    logic [7:0] snp_addr;
    logic       wb_valid;
    logic [7:0] wb_addr, wb_data;

    int n_chk = 0;
    int n_err = 0;

    // Model: 0 = I, 1 = S, 2 = M per line
    int         m_st  [2];
    logic [6:0] m_tag [2];
    logic [7:0] m_dat [2];

    l1_cache_msi_ctrl #(.ADDR_W(8), .DATA_W(8), .INDEX_W(1)) dut (
        .clk(clk), .reset(reset),
        .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
        .cpu_ready(cpu_ready), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
        .msg_valid(msg_valid), .msg_type(msg_type), .msg_addr(msg_addr),
        .fill_valid(fill_valid), .fill_addr(fill_addr), .fill_data(fill_data),
        .snp_valid(snp_valid), .snp_type(snp_type), .snp_addr(snp_addr),
        .wb_valid(wb_valid), .wb_addr(wb_addr), .wb_data(wb_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic model_clear();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_tag[i] = '0; m_dat[i] = '0;
        end
    endtask

    task automatic cpu_txn(input logic we, input logic [7:0] addr, input logic [7:0] wd,
                           input logic [7:0] fd);
        bit         i;
        logic [6:0] t;
        bit         hit;
        int         n;
        logic [7:0] exp_d;
        i   = addr[0];
        t   = addr[7:1];
        hit = (m_st[i] != 0) && (m_tag[i] == t);
        cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wd;
        #1 check("ready", 32'(cpu_ready), 1);
        tick();
        if (hit && (!we || m_st[i] == 2)) begin
            if (we) m_dat[i] = wd;
            check("hit_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, m_dat[i]}));
            check("hit_nomsg", 32'(msg_valid), 0);
        end else if (hit) begin
            check("upg_msg", 32'({msg_valid, msg_type, msg_addr}), 32'({1'b1, 3'b001, addr}));
            check("upg_noack", 32'(cpu_ack), 0);
            tick();
            check("upg_ack", 32'({cpu_ack, msg_valid, cpu_rdata}), 32'({1'b1, 1'b0, wd}));
            m_dat[i] = wd;
            m_st[i]  = 2;
        end else begin
            if (m_st[i] == 2) begin
                check("vic_wb", 32'({wb_valid, wb_addr, wb_data}), 32'({1'b1, m_tag[i], i, m_dat[i]}));
                check("vic_nomsg", 32'(msg_valid), 0);
                tick();
            end
            check("miss_msg", 32'({msg_valid, msg_type, msg_addr}),
                  32'({1'b1, (we ? 3'b010 : 3'b100), addr}));
            check("miss_nowb", 32'(wb_valid), 0);
            n = $urandom_range(1, 4);
            for (int k = 0; k < n; k++) begin
                if ($urandom_range(0, 1) == 1) begin
                    fill_valid = 1'b1; fill_addr = addr ^ 8'h04; fill_data = ~fd;
                end
                tick();
                fill_valid = 1'b0;
                check("wait_quiet", 32'({cpu_ack, msg_valid}), 0);
            end
            fill_valid = 1'b1; fill_addr = addr; fill_data = fd;
            tick();
            fill_valid = 1'b0;
            exp_d = we ? wd : fd;
            check("fill_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, exp_d}));
            m_tag[i] = t;
            m_dat[i] = exp_d;
            m_st[i]  = we ? 2 : 1;
        end
        cpu_req = 1'b0;
        tick();
        check("ack_pulse", 32'({cpu_ack, cpu_ready}), 32'({1'b0, 1'b1}));
    endtask

    task automatic snoop(input logic [2:0] typ, input logic [7:0] addr);
        bit         i;
        bit         hit;
        bit         wb;
        logic [7:0] d;
        i   = addr[0];
        hit = (m_st[i] != 0) && (m_tag[i] == addr[7:1]);
        wb  = hit && (m_st[i] == 2) && (typ != 3'b001);
        d   = m_dat[i];
        snp_valid = 1'b1; snp_type = typ; snp_addr = addr;
        tick();
        snp_valid = 1'b0;
        check("snp_wb", 32'({wb_valid, wb_addr, wb_data}),
              32'({wb, (wb ? addr : 8'h00), (wb ? d : 8'h00)}));
        if (hit) m_st[i] = (typ == 3'b100) ? 1 : 0;
        tick();
        check("snp_wb_pulse", 32'(wb_valid), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
        fill_valid = 1'b0; fill_addr = '0; fill_data = '0;
        snp_valid = 1'b0; snp_type = '0; snp_addr = '0;
        model_clear();
        tick(); tick();
        check("rst_ctl", 32'({cpu_ready, cpu_ack, msg_valid, wb_valid, msg_type}), 0);
        check("rst_data", 32'({cpu_rdata, msg_addr, wb_addr, wb_data}), 0);
        reset = 1'b0;
        #1 check("rst_ready", 32'(cpu_ready), 1);
        tick();

        // Read miss, upgrade, hit, victim write-back, write miss
        cpu_txn(1'b0, 8'h00, 8'h00, 8'h10);
        cpu_txn(1'b1, 8'h00, 8'h55, 8'h00);
        cpu_txn(1'b0, 8'h00, 8'h00, 8'h00);
        cpu_txn(1'b0, 8'h02, 8'h00, 8'h22);
        cpu_txn(1'b1, 8'h00, 8'h55, 8'h99);
        snoop(3'b100, 8'h00);
        snoop(3'b001, 8'h00);
        snoop(3'b100, 8'h00);
        cpu_txn(1'b0, 8'h00, 8'h00, 8'h31);

        // Snoop and CPU request on the same index in the same cycle
        cpu_txn(1'b1, 8'h01, 8'hA1, 8'h00);
        snp_valid = 1'b1; snp_type = 3'b100; snp_addr = 8'h01;
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h03; cpu_wdata = 8'h00;
        #1 check("coll_ready", 32'(cpu_ready), 0);
        tick();
        snp_valid = 1'b0;
        check("coll_wb", 32'({wb_valid, wb_addr, wb_data}), 32'({1'b1, 8'h01, 8'hA1}));
        check("coll_noacc", 32'({cpu_ack, msg_valid}), 0);
        m_st[1] = 1;
        cpu_txn(1'b0, 8'h03, 8'h00, 8'h33);

        // Snoop write-back collides with a victim write-back
        cpu_txn(1'b1, 8'h00, 8'h5A, 8'h00);
        cpu_txn(1'b1, 8'h01, 8'hB1, 8'h00);
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h02;
        snp_valid = 1'b1; snp_type = 3'b010; snp_addr = 8'h01;
        #1 check("wbc_ready", 32'(cpu_ready), 1);
        tick();
        snp_valid = 1'b0;
        check("wbc_snp_wb", 32'({wb_valid, wb_addr, wb_data, msg_valid}), 32'({1'b1, 8'h01, 8'hB1, 1'b0}));
        m_st[1] = 0;
        tick();
        check("wbc_vic_wb", 32'({wb_valid, wb_addr, wb_data, msg_valid}), 32'({1'b1, 8'h00, 8'h5A, 1'b0}));
        tick();
        check("wbc_msg", 32'({msg_valid, msg_type, msg_addr, wb_valid}), 32'({1'b1, 3'b100, 8'h02, 1'b0}));
        tick();
        fill_valid = 1'b1; fill_addr = 8'h02; fill_data = 8'h42;
        tick();
        fill_valid = 1'b0;
        check("wbc_ack", 32'({cpu_ack, cpu_rdata}), 32'({1'b1, 8'h42}));
        cpu_req = 1'b0;
        m_tag[0] = 7'h01; m_dat[0] = 8'h42; m_st[0] = 1;
        tick();
        check("wbc_ack_pulse", 32'(cpu_ack), 0);

        for (int it = 0; it < 200; it++) begin
            logic [7:0] a;
            a = 8'($urandom_range(0, 7));
            if ($urandom_range(0, 9) < 7) begin
                cpu_txn($urandom_range(0, 1) == 1, a, 8'($urandom), 8'($urandom));
            end else begin
                case ($urandom_range(0, 2))
                    0:       snoop(3'b001, a);
                    1:       snoop(3'b010, a);
                    default: snoop(3'b100, a);
                endcase
            end
        end

        // Reset while waiting for a fill
        snoop(3'b001, {m_tag[0], 1'b0});
        cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h04;
        #1 check("rw_ready", 32'(cpu_ready), 1);
        tick();
        check("rw_msg", 32'({msg_valid, msg_type, msg_addr}), 32'({1'b1, 3'b100, 8'h04}));
        tick();
        reset = 1'b1; cpu_req = 1'b0;
        #1 check("rw_ctl", 32'({cpu_ready, cpu_ack, msg_valid, wb_valid, msg_type}), 0);
        check("rw_data", 32'({cpu_rdata, msg_addr, wb_addr, wb_data}), 0);
        model_clear();
        tick();
        reset = 1'b0;
        #1 check("rw_ready_rel", 32'(cpu_ready), 1);
        tick();
        fill_valid = 1'b1; fill_addr = 8'h04; fill_data = 8'h77;
        tick();
        fill_valid = 1'b0;
        check("stale_fill", 32'({cpu_ack, msg_valid, wb_valid}), 0);
        tick();
        check("stale_fill2", 32'(cpu_ack), 0);
        cpu_txn(1'b0, 8'h04, 8'h00, 8'h44);
        cpu_txn(1'b0, 8'h01, 8'h00, 8'h11);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
